// File: rtl/pipelined_adder_if.sv
// Operand/result stream bundle for pipelined_adder.
// The master side is the producer/consumer harness; the slave side is the adder.
interface pipelined_adder_if #(
  parameter int W = 64
);
  logic         valid_i;
  logic         ready_o;
  logic [W-1:0] a_i;
  logic [W-1:0] b_i;
  logic         sub_i;
  logic         valid_o;
  logic         ready_i;
  logic [W:0]   sum_o;
  logic         is_odd_o;
  logic         ovf_o;

  modport master (
    output valid_i, a_i, b_i, sub_i, ready_i,
    input  ready_o, valid_o, sum_o, is_odd_o, ovf_o
  );

  modport slave (
    input  valid_i, a_i, b_i, sub_i, ready_i,
    output ready_o, valid_o, sum_o, is_odd_o, ovf_o
  );
endinterface

// File: rtl/pipelined_adder.sv
// Carry-segmented pipelined adder/subtractor with valid/ready flow control.
// Stage k adds one W/S-bit slice using the carry registered by stage k-1.
// Operands are kept shifted so the slice to add is always in the low bits;
// the result is assembled from the top down so it lands aligned after S stages.
module pipelined_adder #(
  parameter int W = 64,
  parameter int S = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  pipelined_adder_if.slave bus
);
  localparam int SW = W / S;

  if ((S < 1) || (S > W) || ((W % S) != 0)) begin : g_param_check
    $error("pipelined_adder: W must be a multiple of S and 1 <= S <= W");
  end

  // Per-stage registers (index k holds a beat after slice k has been added).
  logic [S-1:0] v_r;
  logic [S-1:0] c_r;
  logic [W-1:0] a_r   [S];
  logic [W-1:0] bp_r  [S];
  logic [W-1:0] sum_r [S];
  logic         ovf_r;

  // Combinational stage inputs/outputs.
  logic [S-1:0] adv_s;
  logic [S-1:0] src_v_s;
  logic [S-1:0] src_c_s;
  logic [S-1:0] nxt_c_s;
  logic [W-1:0] src_a_s   [S];
  logic [W-1:0] src_bp_s  [S];
  logic [W-1:0] src_sum_s [S];
  logic [W-1:0] nxt_a_s   [S];
  logic [W-1:0] nxt_bp_s  [S];
  logic [W-1:0] nxt_sum_s [S];
  logic [SW:0]  slice_s   [S];
  logic         nxt_ovf_s;

  // Advance chain: a stage moves when it is empty or its successor moves.
  always_comb begin
    adv_s = '0;
    adv_s[S-1] = !v_r[S-1] || bus.ready_i;
    for (int k = S - 2; k >= 0; k--) begin
      adv_s[k] = !v_r[k] || adv_s[k+1];
    end
  end

  // Slice adders: stage 0 takes the bus operands, later stages take the previous register.
  always_comb begin
    src_v_s[0]   = bus.valid_i;
    src_a_s[0]   = bus.a_i;
    src_bp_s[0]  = bus.sub_i ? ~bus.b_i : bus.b_i;
    src_c_s[0]   = bus.sub_i;
    src_sum_s[0] = '0;
    for (int k = 1; k < S; k++) begin
      src_v_s[k]   = v_r[k-1];
      src_a_s[k]   = a_r[k-1];
      src_bp_s[k]  = bp_r[k-1];
      src_c_s[k]   = c_r[k-1];
      src_sum_s[k] = sum_r[k-1];
    end
    for (int k = 0; k < S; k++) begin
      slice_s[k]   = {1'b0, src_a_s[k][SW-1:0]} + {1'b0, src_bp_s[k][SW-1:0]}
                   + {{SW{1'b0}}, src_c_s[k]};
      nxt_c_s[k]   = slice_s[k][SW];
      nxt_a_s[k]   = src_a_s[k] >> SW;
      nxt_bp_s[k]  = src_bp_s[k] >> SW;
      nxt_sum_s[k] = (src_sum_s[k] >> SW) | (W'(slice_s[k][SW-1:0]) << (W - SW));
    end
    // In the last stage the operand slice tops are the original sign bits.
    nxt_ovf_s = (src_a_s[S-1][SW-1] == src_bp_s[S-1][SW-1])
             && (slice_s[S-1][SW-1] != src_a_s[S-1][SW-1]);
  end

  // Stage registers: load the predecessor whenever the stage advances; data only moves with a valid beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_r   <= '0;
      c_r   <= '0;
      ovf_r <= 1'b0;
      for (int k = 0; k < S; k++) begin
        a_r[k]   <= '0;
        bp_r[k]  <= '0;
        sum_r[k] <= '0;
      end
    end else begin
      for (int k = 0; k < S; k++) begin
        if (adv_s[k]) begin
          v_r[k] <= src_v_s[k];
          if (src_v_s[k]) begin
            a_r[k]   <= nxt_a_s[k];
            bp_r[k]  <= nxt_bp_s[k];
            c_r[k]   <= nxt_c_s[k];
            sum_r[k] <= nxt_sum_s[k];
          end
        end
      end
      if (adv_s[S-1] && src_v_s[S-1]) begin
        ovf_r <= nxt_ovf_s;
      end
    end
  end

  assign bus.ready_o  = adv_s[0];
  assign bus.valid_o  = v_r[S-1];
  assign bus.sum_o    = {c_r[S-1], sum_r[S-1]};
  assign bus.is_odd_o = sum_r[S-1][0];
  assign bus.ovf_o    = ovf_r;
endmodule

// File: tb/tb_pipelined_adder.sv
// Bench for pipelined_adder: three instances (W64/S4, W8/S2, W8/S1) driven by
// directed vectors plus a random phase, checked against an arithmetic model.
module tb_pipelined_adder;
  logic        clk;
  logic        rst_n;
  logic [2:0]  vin, sub, rdi;
  logic [63:0] ain [3];
  logic [63:0] bin [3];
  logic [2:0]  rdo, vo, odd, ovf;
  logic [64:0] sum [3];

  int n_chk = 0;
  int n_err = 0;

  // Model scoreboard: {ovf, sum[64:0]} per accepted beat, per instance.
  logic [65:0] exp_q [3][64];
  int          wr [3];
  int          rd [3];
  logic [2:0]  stall_prev;
  logic [64:0] held_sum [3];
  logic [1:0]  held_flg [3];

  pipelined_adder_if #(.W(64)) bus0 ();
  pipelined_adder_if #(.W(8))  bus1 ();
  pipelined_adder_if #(.W(8))  bus2 ();

  pipelined_adder #(.W(64), .S(4)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0.slave));
  pipelined_adder #(.W(8),  .S(2)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1.slave));
  pipelined_adder #(.W(8),  .S(1)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2.slave));

  assign bus0.valid_i = vin[0]; assign bus0.a_i = ain[0];      assign bus0.b_i = bin[0];
  assign bus0.sub_i   = sub[0]; assign bus0.ready_i = rdi[0];
  assign bus1.valid_i = vin[1]; assign bus1.a_i = ain[1][7:0]; assign bus1.b_i = bin[1][7:0];
  assign bus1.sub_i   = sub[1]; assign bus1.ready_i = rdi[1];
  assign bus2.valid_i = vin[2]; assign bus2.a_i = ain[2][7:0]; assign bus2.b_i = bin[2][7:0];
  assign bus2.sub_i   = sub[2]; assign bus2.ready_i = rdi[2];

  assign rdo[0] = bus0.ready_o; assign vo[0] = bus0.valid_o; assign sum[0] = bus0.sum_o;
  assign odd[0] = bus0.is_odd_o; assign ovf[0] = bus0.ovf_o;
  assign rdo[1] = bus1.ready_o; assign vo[1] = bus1.valid_o; assign sum[1] = {56'd0, bus1.sum_o};
  assign odd[1] = bus1.is_odd_o; assign ovf[1] = bus1.ovf_o;
  assign rdo[2] = bus2.ready_o; assign vo[2] = bus2.valid_o; assign sum[2] = {56'd0, bus2.sum_o};
  assign odd[2] = bus2.is_odd_o; assign ovf[2] = bus2.ovf_o;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  function automatic int w_of(input int i);
    return (i == 0) ? 64 : 8;
  endfunction

  function automatic int s_of(input int i);
    return (i == 0) ? 4 : ((i == 1) ? 2 : 1);
  endfunction

  // Reference: unsigned A + B or A + (2^w - B) in w+1 bits; overflow from true signed range.
  function automatic logic [65:0] model(input logic [63:0] a, input logic [63:0] b,
                                        input logic s, input int w);
    logic [65:0]        mask, am, bm, tot;
    logic signed [66:0] sa, sb, sr, lim, t;
    logic               o;
    mask = (66'd1 << w) - 66'd1;
    am   = {2'b00, a} & mask;
    bm   = {2'b00, b} & mask;
    tot  = s ? (am + mask + 66'd1 - bm) : (am + bm);
    tot  = tot & ((mask << 1) | 66'd1);
    t    = {1'b0, am} <<< (67 - w);
    sa   = t >>> (67 - w);
    t    = {1'b0, bm} <<< (67 - w);
    sb   = t >>> (67 - w);
    sr   = s ? (sa - sb) : (sa + sb);
    lim  = 67'sd1 <<< (w - 1);
    o    = (sr >= lim) || (sr < -lim);
    return {o, tot[64:0]};
  endfunction

  task automatic chk(input bit ok, input string nm, input logic [65:0] act, input logic [65:0] req);
    n_chk++;
    if (!ok) begin
      n_err++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, req);
    end
  endtask

  // Compare process: one sample per cycle, 1 time unit after the input-driving edge.
  always begin
    int          cnt;
    logic [65:0] e;
    @(negedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      if (!rst_n) begin
        rd[i] = wr[i];
        stall_prev[i] = 1'b0;
        chk(vo[i] == 1'b0, $sformatf("u%0d reset valid_o", i), 66'(vo[i]), 66'd0);
        chk(sum[i] == 65'd0, $sformatf("u%0d reset sum_o", i), 66'(sum[i]), 66'd0);
      end else begin
        cnt = wr[i] - rd[i];
        if (stall_prev[i]) begin
          chk(vo[i] == 1'b1, $sformatf("u%0d hold valid_o", i), 66'(vo[i]), 66'd1);
          chk(sum[i] == held_sum[i] && {ovf[i], odd[i]} == held_flg[i],
              $sformatf("u%0d hold outputs", i), {ovf[i], sum[i]}, {held_flg[i][1], held_sum[i]});
        end
        chk(rdo[i] == ((cnt < s_of(i)) || rdi[i]), $sformatf("u%0d ready_o rule", i),
            66'(rdo[i]), 66'((cnt < s_of(i)) || rdi[i]));
        if (vo[i]) begin
          if (cnt == 0) begin
            chk(1'b0, $sformatf("u%0d unexpected result", i), {ovf[i], sum[i]}, 66'd0);
          end else begin
            e = exp_q[i][rd[i] % 64];
            chk(sum[i] == e[64:0], $sformatf("u%0d sum_o", i), 66'(sum[i]), 66'(e[64:0]));
            chk(odd[i] == e[0], $sformatf("u%0d is_odd_o", i), 66'(odd[i]), 66'(e[0]));
            chk(ovf[i] == e[65], $sformatf("u%0d ovf_o", i), 66'(ovf[i]), 66'(e[65]));
            if (rdi[i]) rd[i] = rd[i] + 1;
          end
        end
        stall_prev[i] = vo[i] && !rdi[i];
        held_sum[i]   = sum[i];
        held_flg[i]   = {ovf[i], odd[i]};
        if (vin[i] && rdo[i]) begin
          exp_q[i][wr[i] % 64] = model(ain[i], bin[i], sub[i], w_of(i));
          wr[i] = wr[i] + 1;
        end
      end
    end
  end

  task automatic drive(input int i, input logic v, input logic [63:0] a, input logic [63:0] b,
                       input logic s);
    vin[i] = v;
    ain[i] = a;
    bin[i] = b;
    sub[i] = s;
  endtask

  // Called at a falling edge right after the beat's valid was dropped; waits for the result.
  task automatic wait_out(input int i, input logic [64:0] es, input logic eo, input int elat,
                          input string nm);
    int lat;
    lat = 0;
    for (int c = 1; c <= 20; c++) begin
      #2;
      if (vo[i]) begin
        lat = c;
        break;
      end
      @(negedge clk);
    end
    chk(lat == elat, {nm, " latency"}, 66'(lat), 66'(elat));
    chk(sum[i] == es, {nm, " sum"}, 66'(sum[i]), 66'(es));
    chk(odd[i] == es[0], {nm, " odd"}, 66'(odd[i]), 66'(es[0]));
    chk(ovf[i] == eo, {nm, " ovf"}, 66'(ovf[i]), 66'(eo));
  endtask

  task automatic one_beat(input int i, input logic [63:0] a, input logic [63:0] b, input logic s,
                          input logic [64:0] es, input logic eo, input string nm);
    @(negedge clk);
    drive(i, 1'b1, a, b, s);
    @(negedge clk);
    vin[i] = 1'b0;
    wait_out(i, es, eo, s_of(i), nm);
  endtask

  function automatic logic [63:0] rnd_op(input int w);
    logic [63:0] m;
    m = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
    case ($urandom_range(0, 7))
      0:       return 64'd0;
      1:       return m;
      2:       return 64'd1 << (w - 1);
      3:       return m >> 1;
      default: return {$urandom, $urandom} & m;
    endcase
  endfunction

  initial begin
    int beat;
    for (int i = 0; i < 3; i++) begin
      wr[i] = 0;
      rd[i] = 0;
      drive(i, 1'b0, 64'd0, 64'd0, 1'b0);
    end
    stall_prev = 3'b000;
    rdi = 3'b111;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Idle after reset.
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      #2;
      chk(vo[0] == 1'b0, "idle valid_o", 66'(vo[0]), 66'd0);
      chk(rdo[0] == 1'b1, "idle ready_o", 66'(rdo[0]), 66'd1);
      chk(sum[0] == 65'd0, "idle sum_o", 66'(sum[0]), 66'd0);
    end

    // Reset with three beats in flight on the 4-stage instance.
    rdi[0] = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      drive(0, 1'b1, 64'(100 + c), 64'(7 * c), 1'b0);
    end
    @(negedge clk);
    vin[0] = 1'b0;
    @(negedge clk);
    #2;
    chk(vo[0] == 1'b1, "inflight valid_o", 66'(vo[0]), 66'd1);
    #1 rst_n = 1'b0;
    #1;
    chk(vo[0] == 1'b0, "async reset valid_o", 66'(vo[0]), 66'd0);
    chk(sum[0] == 65'd0, "async reset sum_o", 66'(sum[0]), 66'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    rdi[0] = 1'b1;
    repeat (8) @(negedge clk);

    // Directed arithmetic vectors.
    one_beat(0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 65'h1_0000_0000_0000_0000, 1'b0, "w64 carry");
    one_beat(1, 64'h05, 64'h07, 1'b1, 65'h0FE, 1'b0, "w8 5-7");
    one_beat(1, 64'h80, 64'h01, 1'b1, 65'h17F, 1'b1, "w8 80-1");
    one_beat(1, 64'h7F, 64'h01, 1'b0, 65'h080, 1'b1, "w8 7f+1");
    one_beat(2, 64'hFF, 64'h01, 1'b0, 65'h100, 1'b0, "s1 ff+1");
    one_beat(2, 64'h80, 64'h80, 1'b0, 65'h100, 1'b1, "s1 80+80");
    one_beat(2, 64'h00, 64'h01, 1'b1, 65'h0FF, 1'b0, "s1 0-1");

    // Back-pressure: 8 beats, consumer stalled on cycles 3..9.
    beat = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      rdi[0] = !(c >= 3 && c <= 9);
      if (beat < 8) drive(0, 1'b1, 64'(beat), 64'(2 * beat), beat[0]);
      else vin[0] = 1'b0;
      #1;
      if (c == 3) chk(rdo[0] == 1'b1, "bp ready before full", 66'(rdo[0]), 66'd1);
      if (c == 4) chk(rdo[0] == 1'b0, "bp ready when full", 66'(rdo[0]), 66'd0);
      if (vin[0] && rdo[0]) beat++;
    end
    chk(beat == 8, "bp beats accepted", 66'(beat), 66'd8);

    // Bubble collapse: beat, two-cycle gap, then beats until full, consumer stalled.
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      rdi[0] = (c >= 7);
      drive(0, (c == 0) || (c >= 3 && c <= 6), 64'(40960 + c), 64'(3 * c), c[0]);
      #1;
      if (c == 5) chk(rdo[0] == 1'b1, "bubble ready at 3", 66'(rdo[0]), 66'd1);
      if (c == 6) chk(rdo[0] == 1'b0, "bubble ready at 4", 66'(rdo[0]), 66'd0);
    end
    vin[0] = 1'b0;

    // Random traffic on all instances.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        rdi[i] = ($urandom_range(0, 9) < 7);
        drive(i, $urandom_range(0, 9) < 7, rnd_op(w_of(i)), rnd_op(w_of(i)), $urandom_range(0, 1) == 1);
      end
    end
    @(negedge clk);
    vin = 3'b000;
    rdi = 3'b111;
    repeat (20) @(negedge clk);
    #2;
    for (int i = 0; i < 3; i++) begin
      chk(wr[i] == rd[i], $sformatf("u%0d drained", i), 66'(wr[i] - rd[i]), 66'd0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
